// File: rtl/soc_bus_pkg.sv
// soc_bus_pkg
//   Shared types and constants for the SoC memory bus arbiter.
//   Contents:
//     arb_state_t      - arbiter FSM state (IDLE, BUSY)
//     M0, M1           - master indices into grant / request vectors
//     BUS_ADDR_W       - default bus address width
//     BUS_DATA_W       - default bus data width
//     DEFAULT_TIMEOUT  - default BUSY-cycle limit when the timeout is built in
package soc_bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int M0 = 0;
  localparam int M1 = 1;

  localparam int BUS_ADDR_W      = 32;
  localparam int BUS_DATA_W      = 32;
  localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_bus_arbiter_rr.sv
// rr_arbiter2
//   Combinational two-way round-robin pick.
//   Ports:
//     req[1:0]    in   request vector, bit0 = m0
//     last_owner  in   master served last (0 = m0, 1 = m1)
//     gnt[1:0]    out  one-hot winner, 0 when nobody requests
module rr_arbiter2
  import soc_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req[M0] && req[M1]) begin
      // Tie: the master that was not served last wins.
      gnt = last_owner ? 2'b01 : 2'b10;
    end else if (req[M0]) begin
      gnt = 2'b01;
    end else if (req[M1]) begin
      gnt = 2'b10;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one valid/ready memory bus between two masters (m0 = CPU,
//   m1 = boot loader / DMA). One outstanding transaction at a time,
//   round-robin on ties, one idle cycle after every completion.
//   Optional feature macro: ARB_TIMEOUT_EN - when defined, a BUSY access
//   that gets no s_ready within TIMEOUT cycles is force-completed with
//   rdata = 0 and a timeout_err pulse.
//   Ports:
//     clk, rstn                       clock, synchronous active-low reset
//     mX_valid/addr/wdata/wstrb       master requests (wstrb = 0 is a read)
//     mX_ready, mX_rdata              completion pulse and read data
//     s_valid/addr/wdata/wstrb        request to the address decoder
//     s_ready, s_rdata                decoder completion and read data
//     grant                           one-hot current owner, 0 when idle
//     timeout_err                     one-cycle pulse on forced completion
//
//   state | meaning
//   IDLE  | bus free; pick a requester and register grant
//   BUSY  | granted master drives the bus; wait for s_ready (or timeout)
module mem_bus_arbiter
  import soc_bus_pkg::*;
#(
  parameter int ADDR_W  = BUS_ADDR_W,
  parameter int DATA_W  = BUS_DATA_W,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                m0_valid,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_ready,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_valid,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_ready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                s_valid,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_ready,
  input  logic [DATA_W-1:0]   s_rdata,
  output logic [1:0]          grant,
  output logic                timeout_err
);

  arb_state_t state_q;
  logic [1:0] grant_q;
  logic       last_q;
  logic [1:0] pick;
  logic       busy;
  logic       tmo_hit;
  logic       done;

  rr_arbiter2 u_rr (
    .req        ({m1_valid, m0_valid}),
    .last_owner (last_q),
    .gnt        (pick)
  );

  assign busy = (state_q == BUSY);

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] busy_cnt_q;

  assign tmo_hit     = busy && (busy_cnt_q == CNT_W'(TIMEOUT));
  // A decoder answer in the timeout cycle wins over the forced completion.
  assign timeout_err = tmo_hit && !s_ready;

  // Holds 1 during the first BUSY cycle, so it equals the BUSY cycle number.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy_cnt_q <= '0;
    end else if (!busy && (pick != 2'b00)) begin
      busy_cnt_q <= CNT_W'(1);
    end else if (busy && !done) begin
      busy_cnt_q <= busy_cnt_q + 1'b1;
    end
  end
`else
  // TIMEOUT only matters when the timeout counter is built in.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign tmo_hit        = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  assign done = busy && (s_ready || tmo_hit);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick != 2'b00) begin
            grant_q <= pick;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (done) begin
            last_q  <= grant_q[M1];
            grant_q <= 2'b00;
            state_q <= IDLE;
          end
        end
        default: begin
          grant_q <= 2'b00;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign s_valid = busy;
  assign grant   = grant_q;
  assign s_addr  = grant_q[M1] ? m1_addr  : m0_addr;
  assign s_wdata = grant_q[M1] ? m1_wdata : m0_wdata;
  assign s_wstrb = grant_q[M1] ? m1_wstrb : m0_wstrb;

  assign m0_ready = done && grant_q[M0];
  assign m1_ready = done && grant_q[M1];

  // Forced completions return zero; rdata is also zero whenever ready is low.
  assign m0_rdata = (m0_ready && s_ready) ? s_rdata : '0;
  assign m1_rdata = (m1_ready && s_ready) ? s_rdata : '0;

endmodule
